midi_rx_parser: RTL and testbench

- Receive side of the MIDI controller.
- Oversamples the raw `midi_rx` pin on the system clock (31250 baud, 8N1) and assembles bytes.
- Parses bytes into complete MIDI messages, with running-status support and real-time pass-through.
- Presents each message as status/data1/data2/bytes_cnt plus a one-cycle valid pulse, for the button-assignment and save logic downstream.

---
 rtl/midi_pkg.sv | 38 +++
 rtl/midi_rx_parser_if.sv | 17 +
 rtl/midi_rx_parser_uart_rx_byte.sv | 117 +++++++++++
 rtl/midi_rx_parser.sv | 92 +++++++++
 tb/tb_midi_rx_parser.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants, message record and status-byte helpers for the receive path.
package midi_pkg;

  localparam logic [7:0] NOTE_OFF = 8'h80;
  localparam logic [7:0] NOTE_ON  = 8'h90;
  localparam logic [7:0] CC_MSG   = 8'hB0;
  localparam logic [7:0] PC_MSG   = 8'hC0;
  localparam logic [7:0] SYSEX    = 8'hF0;
  localparam logic [7:0] EOX      = 8'hF7;
  localparam logic [7:0] RT_MIN   = 8'hF8;
  localparam logic [7:0] TUNE_REQ = 8'hF6;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [1:0] bytes_cnt;
  } midi_msg_t;

  // Number of data bytes that follow a status; 0 means the status never carries data.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hC, 4'hD:                   len = 2'd1;
      4'hF: begin
        case (status[3:0])
          4'h1, 4'h3: len = 2'd1;
          4'h2:       len = 2'd2;
          default:    len = 2'd0;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_rx_parser_if.sv
// Parsed-message bus from the MIDI receiver to the assignment/save logic.
interface midi_rx_parser_if;
  logic [7:0] status_o;
  logic [7:0] data1_o;
  logic [7:0] data2_o;
  logic [1:0] bytes_cnt_o;
  logic       msg_valid_o;
  logic       frame_err_o;

  modport master (
    output status_o, data1_o, data2_o, bytes_cnt_o, msg_valid_o, frame_err_o
  );

  modport slave (
    input status_o, data1_o, data2_o, bytes_cnt_o, msg_valid_o, frame_err_o
  );
endinterface

// File: rtl/midi_rx_parser_uart_rx_byte.sv
// 8N1 oversampling byte receiver with input synchroniser and break handling.
module uart_rx_byte #(
  parameter int BAUD_CNT    = 3200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  localparam logic [12:0] BIT_LAST  = 13'(BAUD_CNT - 1);
  localparam logic [12:0] HALF_LAST = 13'(BAUD_CNT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_s;
  logic                   rx_prev_r;
  logic [2:0]             state_r;
  logic [12:0]            bitcnt_r;
  logic [2:0]             bitidx_r;
  logic [7:0]             shift_r;
  logic [7:0]             byte_r;
  logic                   byte_valid_r;
  logic                   frame_err_r;

  assign rx_s = sync_r[SYNC_STAGES-1];

  // Metastability synchroniser plus one-cycle history for start-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r    <= '1;
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], rx};
      rx_prev_r <= rx_s;
    end
  end

  // Byte framing FSM: start qualification at mid-bit, then one sample per bit period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      bitcnt_r     <= 13'd0;
      bitidx_r     <= 3'd0;
      shift_r      <= 8'h00;
      byte_r       <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rx_prev_r && !rx_s) begin
            bitcnt_r <= 13'd0;
            state_r  <= START;
          end
        end
        START: begin
          if (bitcnt_r == HALF_LAST) begin
            bitcnt_r <= 13'd0;
            bitidx_r <= 3'd0;
            state_r  <= rx_s ? IDLE : DATA;
          end else begin
            bitcnt_r <= bitcnt_r + 13'd1;
          end
        end
        DATA: begin
          if (bitcnt_r == BIT_LAST) begin
            bitcnt_r <= 13'd0;
            shift_r  <= {rx_s, shift_r[7:1]};
            bitidx_r <= bitidx_r + 3'd1;
            if (bitidx_r == 3'd7) begin
              state_r <= STOP;
            end
          end else begin
            bitcnt_r <= bitcnt_r + 13'd1;
          end
        end
        STOP: begin
          if (bitcnt_r == BIT_LAST) begin
            bitcnt_r <= 13'd0;
            if (rx_s) begin
              byte_r       <= shift_r;
              byte_valid_r <= 1'b1;
              state_r      <= IDLE;
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= BREAK;
            end
          end else begin
            bitcnt_r <= bitcnt_r + 13'd1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign byte_o       = byte_r;
  assign byte_valid_o = byte_valid_r;
  assign frame_err_o  = frame_err_r;

endmodule

// File: rtl/midi_rx_parser.sv
// MIDI receive path: byte receiver plus message parser with running status and real-time pass-through.
module midi_rx_parser
  import midi_pkg::*;
#(
  parameter int BAUD_CNT    = 3200,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    midi_rx,
  midi_rx_parser_if.master        msg
);

  logic [7:0] rx_byte_s;
  logic       byte_valid_s;
  logic       frame_err_s;

  uart_rx_byte #(
    .BAUD_CNT   (BAUD_CNT),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx          (midi_rx),
    .byte_o      (rx_byte_s),
    .byte_valid_o(byte_valid_s),
    .frame_err_o (frame_err_s)
  );

  midi_msg_t  msg_r;
  logic       msg_valid_r;
  logic [7:0] run_status_r;
  logic [7:0] data1_r;
  logic       idx_r;
  logic       sysex_r;
  logic [1:0] len_s;

  // run_status_r only ever holds statuses that take data, so len_s==0 means "no status held".
  assign len_s = midi_data_len(run_status_r);

  // Message assembly; outputs register on the byte_valid cycle so msg_valid lands one clock later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_r        <= '0;
      msg_valid_r  <= 1'b0;
      run_status_r <= 8'h00;
      data1_r      <= 8'h00;
      idx_r        <= 1'b0;
      sysex_r      <= 1'b0;
    end else begin
      msg_valid_r <= 1'b0;
      if (byte_valid_s) begin
        if (rx_byte_s >= RT_MIN) begin
          msg_r       <= '{rx_byte_s, 8'h00, 8'h00, 2'd1};
          msg_valid_r <= 1'b1;
        end else if (rx_byte_s[7]) begin
          idx_r        <= 1'b0;
          sysex_r      <= (rx_byte_s == SYSEX);
          run_status_r <= (midi_data_len(rx_byte_s) != 2'd0) ? rx_byte_s : 8'h00;
          if (rx_byte_s == TUNE_REQ) begin
            msg_r       <= '{rx_byte_s, 8'h00, 8'h00, 2'd1};
            msg_valid_r <= 1'b1;
          end
        end else if (!sysex_r && (len_s != 2'd0)) begin
          if (!idx_r && (len_s == 2'd2)) begin
            data1_r <= rx_byte_s;
            idx_r   <= 1'b1;
          end else begin
            msg_r.status    <= run_status_r;
            msg_r.data1     <= (len_s == 2'd1) ? rx_byte_s : data1_r;
            msg_r.data2     <= (len_s == 2'd1) ? 8'h00 : rx_byte_s;
            msg_r.bytes_cnt <= len_s + 2'd1;
            msg_valid_r     <= 1'b1;
            idx_r           <= 1'b0;
            // System common messages do not establish running status.
            if (run_status_r[7:4] == 4'hF) begin
              run_status_r <= 8'h00;
            end
          end
        end
      end
    end
  end

  assign msg.status_o    = msg_r.status;
  assign msg.data1_o     = msg_r.data1;
  assign msg.data2_o     = msg_r.data2;
  assign msg.bytes_cnt_o = msg_r.bytes_cnt;
  assign msg.msg_valid_o = msg_valid_r;
  assign msg.frame_err_o = frame_err_s;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Self-checking bench for midi_rx_parser: serial stimulus table, scoreboard queue, corner-case sequences.
module tb_midi_rx_parser;
  import midi_pkg::*;

  localparam int BAUD = 16;
  localparam int SYNC = 2;
  localparam int GAP  = 4;
  // Clock edges from driving the start bit to msg_valid seen: synchroniser, edge detect,
  // half-bit start check, nine bit periods to the stop sample, one register stage.
  localparam int LAT  = SYNC + BAUD / 2 + 9 * BAUD + 2;

  typedef struct {
    logic [7:0] b;
    logic       exp;
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic midi_rx = 1'b1;

  midi_rx_parser_if mif ();

  midi_rx_parser #(.BAUD_CNT(BAUD), .SYNC_STAGES(SYNC)) dut (
    .clk    (clk),
    .rst    (rst),
    .midi_rx(midi_rx),
    .msg    (mif)
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  int        pulses = 0;
  int        ferrs  = 0;
  int        pushed = 0;
  int        cyc    = 0;
  int        last_valid_cyc = 0;
  int        t_start = 0;
  logic      prev_valid = 1'b0;
  logic      prev_ferr  = 1'b0;
  midi_msg_t exp_q[$];
  vec_t      vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every msg_valid pulse pops one expected message.
  always @(negedge clk) begin
    midi_msg_t got;
    midi_msg_t e;
    if (mif.msg_valid_o) begin
      pulses++;
      last_valid_cyc = cyc;
      got = '{mif.status_o, mif.data1_o, mif.data2_o, mif.bytes_cnt_o};
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL msg_valid_width: high for 2+ clks at cycle %0d, required 1", cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_msg: got %h %h %h cnt %0d, required no message",
                 got.status, got.data1, got.data2, got.bytes_cnt);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL msg_fields: got %h %h %h cnt %0d, required %h %h %h cnt %0d",
                   got.status, got.data1, got.data2, got.bytes_cnt,
                   e.status, e.data1, e.data2, e.bytes_cnt);
        end
      end
    end
    if (mif.frame_err_o) begin
      ferrs++;
      checks++;
      if (prev_ferr) begin
        errors++;
        $display("FAIL frame_err_width: high for 2+ clks at cycle %0d, required 1", cyc);
      end
    end
    prev_valid = mif.msg_valid_o;
    prev_ferr  = mif.frame_err_o;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                      input logic [1:0] cnt);
    exp_q.push_back('{st, d1, d2, cnt});
    pushed++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    t_start = cyc;
    midi_rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      tick(BAUD);
    end
    midi_rx = stop_ok;
    tick(BAUD);
    midi_rx = 1'b1;
    tick(GAP);
  endtask

  task automatic add(input logic [7:0] b, input logic exp, input logic [7:0] st,
                     input logic [7:0] d1, input logic [7:0] d2, input logic [1:0] cnt);
    vecs.push_back('{b, exp, st, d1, d2, cnt});
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {mif.status_o, mif.data1_o, mif.data2_o, 6'd0, mif.bytes_cnt_o,
                 mif.msg_valid_o, mif.frame_err_o}, 32'd0);
  endtask

  initial begin
    int p0;
    int f0;

    // Running status, real-time interleave, sysex, system common and abort cases.
    add(8'hC0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h42, 1'b1, 8'hC0, 8'h42, 8'h00, 2'd2);
    add(8'h43, 1'b1, 8'hC0, 8'h43, 8'h00, 2'd2);
    add(8'h90, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h3C, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'hF8, 1'b1, 8'hF8, 8'h00, 8'h00, 2'd1);
    add(8'h64, 1'b1, 8'h90, 8'h3C, 8'h64, 2'd3);
    add(8'h3E, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h40, 1'b1, 8'h90, 8'h3E, 8'h40, 2'd3);
    add(8'hF0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h02, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'hF7, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h05, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'hF2, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h10, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h20, 1'b1, 8'hF2, 8'h10, 8'h20, 2'd3);
    add(8'h30, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'hF6, 1'b1, 8'hF6, 8'h00, 8'h00, 2'd1);
    add(8'h90, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h50, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'hE0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h02, 1'b1, 8'hE0, 8'h01, 8'h02, 2'd3);
    add(8'hF1, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h11, 1'b1, 8'hF1, 8'h11, 8'h00, 2'd2);
    add(8'h12, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);

    rst = 1'b0;
    midi_rx = 1'b1;
    tick(5);
    check_outputs_zero("reset_outputs");
    rst = 1'b1;
    tick(10);

    // First three-byte message, with latency from the start bit of the completing byte.
    send_byte(8'hB0, 1'b1);
    send_byte(8'h2E, 1'b1);
    push(8'hB0, 8'h2E, 8'h7F, 2'd3);
    send_byte(8'h7F, 1'b1);
    check("first_msg_latency", last_valid_cyc - t_start, LAT);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].exp) push(vecs[i].st, vecs[i].d1, vecs[i].d2, vecs[i].cnt);
      send_byte(vecs[i].b, 1'b1);
    end
    tick(50);
    check("table_queue_drained", exp_q.size(), 0);

    // Short low glitch must be rejected at the start-bit check.
    p0 = pulses;
    f0 = ferrs;
    midi_rx = 1'b0;
    tick(8);
    midi_rx = 1'b1;
    tick(200);
    check("glitch_no_msg", pulses, p0);
    check("glitch_no_ferr", ferrs, f0);

    // Stop bit held low: one frame error, no message.
    send_byte(8'h55, 1'b0);
    tick(50);
    check("stop_low_ferr", ferrs, f0 + 1);
    check("stop_low_no_msg", pulses, p0);

    // 40 low clocks frame as start + bit0 low, rest high -> 0xFE, a real-time byte.
    push(8'hFE, 8'h00, 8'h00, 2'd1);
    midi_rx = 1'b0;
    tick(40);
    midi_rx = 1'b1;
    tick(200);
    send_byte(8'hB0, 1'b1);
    send_byte(8'h07, 1'b1);
    push(8'hB0, 8'h07, 8'h7F, 2'd3);
    send_byte(8'h7F, 1'b1);
    tick(50);
    check("long_low_queue_drained", exp_q.size(), 0);
    check("long_low_ferr", ferrs, f0 + 1);

    // Reset after the second data bit of data2 discards everything.
    p0 = pulses;
    send_byte(8'hB0, 1'b1);
    send_byte(8'h07, 1'b1);
    midi_rx = 1'b0;
    tick(BAUD);
    midi_rx = 1'b1;
    tick(2 * BAUD);
    rst = 1'b0;
    #1;
    check_outputs_zero("mid_byte_reset_outputs");
    tick(3);
    midi_rx = 1'b1;
    rst = 1'b1;
    tick(40);
    send_byte(8'h07, 1'b1);
    tick(50);
    check("post_reset_no_msg", pulses, p0);
    check_outputs_zero("post_reset_outputs");

    check("total_pulses", pulses, pushed);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
